// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, event layout and decoder states for the PS/2 key scanner
//
// Contents:
//   EV_*            event word width and field bit positions ({rpt, brk, ext, code})
//   BYTE_*          prefix and ignored scan-code bytes
//   dec_state_e     decoder prefix-tracking states
//   DEFAULT_KEYMAP  16-entry {ext, code} map, entry i at bits [9i+8:9i]
//   is_ignored()    true for bytes that never produce an event
package ps2_pkg;

  localparam int EV_W   = 11;
  localparam int EV_RPT = 10;
  localparam int EV_BRK = 9;
  localparam int EV_EXT = 8;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;

  // Keyboard housekeeping responses (BAT ok, echo, ack, resend, errors, pause lead-in)
  localparam logic [7:0] IGN_00 = 8'h00;
  localparam logic [7:0] IGN_AA = 8'hAA;
  localparam logic [7:0] IGN_EE = 8'hEE;
  localparam logic [7:0] IGN_FA = 8'hFA;
  localparam logic [7:0] IGN_FE = 8'hFE;
  localparam logic [7:0] IGN_FF = 8'hFF;
  localparam logic [7:0] IGN_E1 = 8'hE1;

  typedef enum logic [1:0] {
    DEC_IDLE = 2'd0,
    DEC_E0   = 2'd1,
    DEC_F0   = 2'd2,
    DEC_E0F0 = 2'd3
  } dec_state_e;

  // Highest index first so that entry 0 lands in the low bits.
  localparam logic [143:0] DEFAULT_KEYMAP = {
    9'h05A,  // 15 enter
    9'h029,  // 14 space
    9'h046,  // 13 num_9
    9'h045,  // 12 num_0
    9'h049,  // 11 period
    9'h041,  // 10 comma
    9'h174,  //  9 right
    9'h16B,  //  8 left
    9'h172,  //  7 down
    9'h175,  //  6 up
    9'h034,  //  5 g
    9'h02B,  //  4 f
    9'h023,  //  3 d
    9'h01B,  //  2 s
    9'h01C,  //  1 a
    9'h01D   //  0 w
  };

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == IGN_00) || (b == IGN_AA) || (b == IGN_EE) || (b == IGN_FA) ||
           (b == IGN_FE) || (b == IGN_FF) || (b == IGN_E1);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 frame receiver with synchronisers, frame check and mid-frame timeout
//
// Ports:
//   clk, clrn    system clock, asynchronous active-low reset
//   ps2_clk      raw PS/2 clock (3-flop synchronised, sampled on falling edge)
//   ps2_data     raw PS/2 data (2-flop synchronised)
//   byte_valid   one-cycle pulse in the cycle the stop bit of a good frame is sampled
//   data_byte    received byte, valid with byte_valid
//   err          one-cycle pulse for a rejected frame or a mid-frame timeout
module ps2_frame_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] data_byte,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    clk_sync;
  logic [1:0]    data_sync;
  logic [3:0]    bit_cnt;
  logic [9:0]    shift_q;
  logic [TW-1:0] idle_cnt;
  logic          fall;
  logic          last_bit;
  logic          frame_ok;
  logic          timeout;

  // Idle-high reset values keep a spurious falling edge out of the first cycles.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= 3'b111;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign fall     = clk_sync[2] & ~clk_sync[1];
  assign last_bit = fall && (bit_cnt == 4'd10);

  // After ten shifts: shift_q[0] = start, [8:1] = data, [9] = parity; stop is the live sample.
  assign frame_ok = ~shift_q[0] & data_sync[1] & (^shift_q[9:1]);
  assign timeout  = (bit_cnt != 4'd0) && !fall && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt  <= 4'd0;
      shift_q  <= 10'd0;
      idle_cnt <= '0;
    end else if (timeout || last_bit) begin
      bit_cnt  <= 4'd0;
      idle_cnt <= '0;
    end else if (fall) begin
      bit_cnt  <= bit_cnt + 4'd1;
      shift_q  <= {data_sync[1], shift_q[9:1]};
      idle_cnt <= '0;
    end else if (bit_cnt != 4'd0) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign byte_valid = last_bit & frame_ok;
  assign data_byte  = shift_q[8:1];
  assign err        = (last_bit & ~frame_ok) | timeout;

endmodule

// File: rtl/ps2_key_scanner.sv
// rtl/ps2_key_scanner.sv - PS/2 keyboard front end: prefix decoder, key map, key levels, event FIFO
//
// Ports:
//   clk, clrn   system clock, asynchronous active-low reset
//   ps2_clk     raw PS/2 clock
//   ps2_data    raw PS/2 data
//   key_state   level per mapped key, 1 = held
//   ev_valid    event FIFO non-empty
//   ev_ready    consumer accepts the head entry
//   ev_data     head entry {rpt, brk, ext, code[7:0]} (zero while empty)
//   ev_count    FIFO occupancy
//   frame_err   one-cycle pulse per rejected or timed-out frame
//   overflow    one-cycle pulse per event dropped on a full FIFO
module ps2_key_scanner
  import ps2_pkg::*;
#(
  parameter int                    NUM_KEYS       = 16,
  parameter logic [9*NUM_KEYS-1:0] KEYMAP         = DEFAULT_KEYMAP,
  parameter int                    FIFO_DEPTH     = 8,
  parameter int                    TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [NUM_KEYS-1:0]           key_state,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [10:0]                   ev_data,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic             rx_valid;
  logic             rx_err;
  logic [7:0]       rx_byte;

  dec_state_e       state_q;
  dec_state_e       state_d;
  logic             key_ev;
  logic             ev_ext;
  logic             ev_brk;
  logic             ev_rpt;
  logic [EV_W-1:0]  ev_word;

  logic [NUM_KEYS-1:0] sel;
  logic                hit;

  logic [EV_W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             pop;
  logic             do_push;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(rx_valid),
    .data_byte (rx_byte),
    .err       (rx_err)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= DEC_IDLE;
    else       state_q <= state_d;
  end

  // Repeated prefixes in a state that already holds them leave the state as is.
  always_comb begin
    state_d = state_q;
    key_ev  = 1'b0;
    if (rx_err) begin
      state_d = DEC_IDLE;
    end else if (rx_valid) begin
      if (rx_byte == BYTE_E0) begin
        if (state_q == DEC_IDLE)    state_d = DEC_E0;
        else if (state_q == DEC_F0) state_d = DEC_E0F0;
      end else if (rx_byte == BYTE_F0) begin
        if (state_q == DEC_IDLE)    state_d = DEC_F0;
        else if (state_q == DEC_E0) state_d = DEC_E0F0;
      end else if (is_ignored(rx_byte)) begin
        state_d = DEC_IDLE;
      end else begin
        key_ev  = 1'b1;
        state_d = DEC_IDLE;
      end
    end
  end

  assign ev_ext = (state_q == DEC_E0) || (state_q == DEC_E0F0);
  assign ev_brk = (state_q == DEC_F0) || (state_q == DEC_E0F0);

  // One-hot select of the lowest matching map entry; all-zero for unmapped codes.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!hit && (KEYMAP[9*i +: 9] == {ev_ext, rx_byte})) begin
        sel[i] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

  assign ev_rpt = ~ev_brk & (|(sel & key_state));

  always_comb begin
    ev_word         = '0;
    ev_word[EV_RPT] = ev_rpt;
    ev_word[EV_BRK] = ev_brk;
    ev_word[EV_EXT] = ev_ext;
    ev_word[7:0]    = rx_byte;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      key_state <= '0;
    end else if (key_ev) begin
      if (ev_brk) key_state <= key_state & ~sel;
      else        key_state <= key_state | sel;
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign full    = (ev_count == CW'(FIFO_DEPTH));
  assign pop     = ev_valid & ev_ready;
  assign do_push = key_ev & (~full | pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= ev_word;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ev_count  <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= rx_err;
      overflow  <= key_ev & full & ~pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      ev_count <= ev_count + 1'b1;
      else if (pop && !do_push) ev_count <= ev_count - 1'b1;
    end
  end

  assign ev_valid = (ev_count != '0);
  assign ev_data  = ev_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_ps2_key_scanner.sv
// tb/tb_ps2_key_scanner.sv - self-checking bench for ps2_key_scanner
module tb_ps2_key_scanner;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        clrn;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] key_state;
  logic        ev_valid;
  logic        ev_ready;
  logic [10:0] ev_data;
  logic [3:0]  ev_count;
  logic        frame_err;
  logic        overflow;

  ps2_key_scanner #(
    .NUM_KEYS(16),
    .FIFO_DEPTH(8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_state(key_state),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_data  (ev_data),
    .ev_count (ev_count),
    .frame_err(frame_err),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [10:0] got[$];

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overflow) ov_cnt++;
    if (ev_valid && ev_ready) got.push_back(ev_data);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] b, input bit badpar);
    logic par;
    par = ~(^b) ^ badpar;
    return {1'b1, par, b, 1'b0};
  endfunction

  // Sends the first nbits of frame f. With pr set, ev_ready is raised for exactly the
  // clk cycle in which the DUT samples the final bit.
  task automatic send_frame(input logic [10:0] f, input int nbits, input bit pr);
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk) ps2_data = f[k];
      repeat (3) @(negedge clk);
      ps2_clk = 1'b0;
      if (pr && k == nbits - 1) begin
        @(negedge clk);
        @(negedge clk) ev_ready = 1'b1;
        @(negedge clk) ev_ready = 1'b0;
        repeat (2) @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
      end
      ps2_clk = 1'b1;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(mkframe(b, 1'b0), 11, 1'b0);
  endtask

  typedef struct {
    int              n;
    logic [0:2][7:0] bs;
    bit              has_ev;
    logic [10:0]     ev;
    logic [15:0]     ks;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  logic [10:0] drain_exp[8];
  int base_ev;
  int base_fe;
  int base_ov;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1, {8'h1D, 8'h00, 8'h00}, 1'b1, 11'h01D, 16'h0001};
    vecs[1]  = '{2, {8'hF0, 8'h1D, 8'h00}, 1'b1, 11'h21D, 16'h0000};
    vecs[2]  = '{2, {8'hE0, 8'h75, 8'h00}, 1'b1, 11'h175, 16'h0040};
    vecs[3]  = '{3, {8'hE0, 8'hF0, 8'h75}, 1'b1, 11'h375, 16'h0000};
    vecs[4]  = '{1, {8'h75, 8'h00, 8'h00}, 1'b1, 11'h075, 16'h0000};
    vecs[5]  = '{1, {8'h1C, 8'h00, 8'h00}, 1'b1, 11'h01C, 16'h0002};
    vecs[6]  = '{1, {8'h1C, 8'h00, 8'h00}, 1'b1, 11'h41C, 16'h0002};
    vecs[7]  = '{1, {8'h1C, 8'h00, 8'h00}, 1'b1, 11'h41C, 16'h0002};
    vecs[8]  = '{2, {8'hF0, 8'h1C, 8'h00}, 1'b1, 11'h21C, 16'h0000};
    vecs[9]  = '{1, {8'hAA, 8'h00, 8'h00}, 1'b0, 11'h000, 16'h0000};
    vecs[10] = '{3, {8'hE0, 8'hFA, 8'h1D}, 1'b1, 11'h01D, 16'h0001};
    vecs[11] = '{2, {8'hF0, 8'h1D, 8'h00}, 1'b1, 11'h21D, 16'h0000};
    vecs[12] = '{2, {8'hE0, 8'h74, 8'h00}, 1'b1, 11'h174, 16'h0200};
    vecs[13] = '{3, {8'hE0, 8'hF0, 8'h74}, 1'b1, 11'h374, 16'h0000};

    drain_exp = '{11'h01C, 11'h01B, 11'h023, 11'h02B, 11'h034, 11'h175, 11'h172, 11'h174};

    clrn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; ev_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_key_state", key_state, 0);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_ev_count", ev_count, 0);
    chk("rst_ev_data", ev_data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overflow", overflow, 0);
    clrn = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      base_ev = got.size();
      base_fe = fe_cnt;
      for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].bs[j]);
      repeat (4) @(negedge clk);
      chk($sformatf("v%0d_nev", i), got.size() - base_ev, vecs[i].has_ev ? 1 : 0);
      if (vecs[i].has_ev && got.size() > base_ev)
        chk($sformatf("v%0d_ev", i), got[base_ev], vecs[i].ev);
      chk($sformatf("v%0d_keys", i), key_state, vecs[i].ks);
      chk($sformatf("v%0d_ferr", i), fe_cnt - base_fe, 0);
    end

    // Wrong parity bit
    base_ev = got.size(); base_fe = fe_cnt;
    send_frame(mkframe(8'h1D, 1'b1), 11, 1'b0);
    repeat (4) @(negedge clk);
    chk("par_ferr", fe_cnt - base_fe, 1);
    chk("par_nev", got.size() - base_ev, 0);
    chk("par_keys", key_state, 16'h0000);

    // Partial frame then silence
    base_fe = fe_cnt;
    send_frame(mkframe(8'h1D, 1'b0), 4, 1'b0);
    repeat (TMO + 10) @(negedge clk);
    chk("tmo_ferr", fe_cnt - base_fe, 1);
    base_ev = got.size();
    send_byte(8'h1B);
    repeat (4) @(negedge clk);
    chk("tmo_nev", got.size() - base_ev, 1);
    if (got.size() > base_ev) chk("tmo_ev", got[base_ev], 11'h01B);
    chk("tmo_keys", key_state, 16'h0004);
    chk("tmo_ferr2", fe_cnt - base_fe, 1);
    send_byte(8'hF0); send_byte(8'h1B);
    repeat (4) @(negedge clk);

    // FIFO full: nine makes with the consumer stalled
    ev_ready = 1'b0;
    got.delete();
    base_ov = ov_cnt;
    send_byte(8'h1D); send_byte(8'h1C); send_byte(8'h1B); send_byte(8'h23);
    send_byte(8'h2B); send_byte(8'h34);
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'h72);
    send_byte(8'hE0); send_byte(8'h6B);
    repeat (4) @(negedge clk);
    chk("full_count", ev_count, 8);
    chk("full_ovf", ov_cnt - base_ov, 1);
    chk("full_keys", key_state, 16'h01FF);
    chk("full_npop", got.size(), 0);

    // Push and pop in the same cycle while full
    send_byte(8'hE0);
    send_frame(mkframe(8'h74, 1'b0), 11, 1'b1);
    repeat (4) @(negedge clk);
    chk("pp_count", ev_count, 8);
    chk("pp_ovf", ov_cnt - base_ov, 1);
    chk("pp_npop", got.size(), 1);
    if (got.size() > 0) chk("pp_head", got[0], 11'h01D);
    chk("pp_keys", key_state, 16'h03FF);

    ev_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk("drain_n", got.size(), 9);
    for (int i = 0; i < 8; i++)
      if (got.size() > i + 1) chk($sformatf("drain%0d", i), got[i + 1], drain_exp[i]);
    chk("drain_count", ev_count, 0);

    // Reset in the middle of a frame with a pending event
    ev_ready = 1'b0;
    send_byte(8'h1D);
    repeat (4) @(negedge clk);
    chk("pre_rst_valid", ev_valid, 1);
    send_frame(mkframe(8'h23, 1'b0), 6, 1'b0);
    clrn = 1'b0;
    @(negedge clk);
    chk("mid_rst_keys", key_state, 0);
    chk("mid_rst_valid", ev_valid, 0);
    chk("mid_rst_count", ev_count, 0);
    chk("mid_rst_data", ev_data, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    got.delete();
    base_fe = fe_cnt;
    clrn = 1'b1;
    ev_ready = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'h23);
    repeat (TMO + 10) @(negedge clk);
    chk("post_rst_nev", got.size(), 1);
    if (got.size() > 0) chk("post_rst_ev", got[0], 11'h023);
    chk("post_rst_keys", key_state, 16'h0008);
    chk("post_rst_ferr", fe_cnt - base_fe, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_scanner.md
# ps2_key_scanner

- Parametrised PS/2 keyboard front end; successor to the fixed 14-key decoder.
- Receives PS/2 frames and checks them. Tracks make/break state for a configurable key map. Detects typematic repeats.
- Queues every decoded key event in a FIFO so that game logic can consume edges as well as level state.
- Sits between the board PS/2 pins and the game controller. It replaces the one-register-per-key output style.

## Interface
- NUM_KEYS, 16: number of tracked keys. Width of key_state.
- KEYMAP, 9*NUM_KEYS bits: entry i is {ext, code} at bits [9i+8:9i]. The default map is listed under Operation.
- FIFO_DEPTH, 8: event FIFO entries. Must be a power of two, ≥2.
- TIMEOUT_CYCLES, 50000: idle clk cycles allowed mid-frame before resync.

- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- ps2_clk  in  1  raw PS/2 clock
- ps2_data  in  1  raw PS/2 data
- key_state  out  NUM_KEYS  level per mapped key; 1 = held
- ev_valid  out  1  FIFO non-empty
- ev_ready  in  1  consumer accepts the head entry
- ev_data  out  11  {rpt, brk, ext, code[7:0]}
- ev_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
- frame_err  out  1  one-cycle pulse per rejected or timed-out frame
- overflow  out  1  one-cycle pulse per event dropped on full

## Operation
- **Reset values:** all outputs 0 during reset. FIFO is empty. Decoder is in IDLE. Bit counter is 0.
- **Input synchronisation:** ps2_clk goes through a 3-flop synchroniser. ps2_data goes through 2 flops. A sample is taken on each detected ps2_clk falling edge.
- **Frame reception:** 11 bits, LSB first: start, 8 data, parity, stop.
  - Accepted when start=0, stop=1 and data^parity has odd parity. Any other frame is discarded with a frame_err pulse.
  - Timeout: if the bit counter is non-zero and no falling edge arrives for TIMEOUT_CYCLES cycles, the counter returns to 0 and frame_err pulses.
- **Decoder FSM** (states IDLE, E0, F0, E0F0), driven by accepted bytes:
  - 0xE0: IDLE→E0, F0→E0F0.
  - 0xF0: IDLE→F0, E0→E0F0.
  - Any other byte is a key code. It produces an event with ext = (state ∈ {E0, E0F0}) and brk = (state ∈ {F0, E0F0}), then the FSM returns to IDLE.
  - Ignored bytes: 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF, 0xE1. These produce no event and the FSM returns to IDLE.
  - A frame error also returns the FSM to IDLE.
- **Key map lookup:** {ext, code} is compared against every KEYMAP entry. On a match at index i:
  - Make: key_state[i] is set. rpt=1 if it was already set.
  - Break: key_state[i] is cleared. rpt=0.
  - Unmapped codes still produce an event, with rpt=0.
  - If a code appears twice in KEYMAP, the lowest index wins.
- **Default KEYMAP, index: key:**
  - 0 w 1D, 1 a 1C, 2 s 1B, 3 d 23, 4 f 2B, 5 g 34
  - 6 up E0-75, 7 down E0-72, 8 left E0-6B, 9 right E0-74
  - 10 comma 41, 11 period 49, 12 num_0 45, 13 num_9 46, 14 space 29, 15 enter 5A
  - ext must match exactly. 0x75 received without E0 is an unmapped event.
- **Event FIFO:** first-word fall-through.
  - ev_data is the head entry whenever ev_valid=1.
  - Pop occurs on ev_valid & ev_ready.
  - Push while full with no pop in the same cycle: the event is dropped and overflow pulses. key_state still updates.
  - Push and pop in the same cycle while full: both succeed and count is unchanged.
  - Push and pop in the same cycle while empty: the push occurs and the pop is ignored, since ev_valid=0.

## Timing
- The sample of the stop bit occurs in cycle T. key_state, the FIFO write and frame_err all appear at T+1.
- If the FIFO was empty, ev_valid rises at T+1 with ev_data valid.
- Prefix bytes (E0, F0) change only the FSM state. They have no visible output.
- ev_count reflects each push or pop on the following cycle.
- Asserting clrn mid-frame aborts the frame and empties the FIFO. A partially received frame produces no event after reset is released.

## Structure
- Shared package ps2_pkg:
  - event field widths and bit positions
  - prefix and ignored byte constants
  - decoder state enum
  - DEFAULT_KEYMAP constant
- Sub-module ps2_frame_rx:
  - synchronisers, bit counter, shift register, parity/start/stop check, timeout counter
  - outputs: byte_valid pulse, byte[7:0], err pulse
- Top level: decoder FSM, key map compare, key_state registers, FIFO (inline circular buffer).

## Test plan
- **Plain make/break:** send 1D, then F0 1D. Required: key_state[0] goes 1 then 0. Events are 0x01D then 0x21D.
- **Extended key:** send E0 75, then E0 F0 75. Required: key_state[6] toggles 1→0. Events are 0x175 then 0x375. Send a bare 75: event 0x075 and key_state unchanged.
- **Typematic repeat:** send 1C three times. Required: key_state[1]=1. Events are 0x01C, then 0x41C twice.
- **Bad frames:** send 1D with a wrong parity bit. Required: frame_err pulses once, no event, key_state unchanged. Send 4 bits, then stay idle for TIMEOUT_CYCLES+1 cycles: frame_err pulses. A following valid 1B frame decodes correctly.
- **FIFO full:** hold ev_ready=0 and send 9 makes with FIFO_DEPTH=8. Required: ev_count=8, one overflow pulse, and key_state reflects all 9 keys. Then push and pop in the same cycle: count stays 8.
- **Reset mid-frame:** assert clrn low after 6 bits, then release and send 23. Required: all outputs 0 during reset, then a single event 0x023 and key_state[3]=1.
